// File: rtl/sa0_test_sequencer.sv
// Sweeps BCD codes 0..9 into a converter under test and accumulates the
// stuck-at-0 flags returned by the checker into a per-sweep fault summary.
module sa0_test_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dut_q,
    output logic [3:0] chk_din,
    output logic [3:0] chk_q,
    input  logic [3:0] chk_sa0out,
    output logic       busy,
    output logic       done,
    output logic [3:0] fault_mask,
    output logic [3:0] fault_code_cnt,
    output logic [3:0] first_fail_code,
    output logic       first_fail_valid
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_CODE   = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_CHECK,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] code_q,  code_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] cap_q,   cap_d;
    logic [3:0] mask_q,  mask_d;
    logic [3:0] nflt_q,  nflt_d;
    logic [3:0] ffc_q,   ffc_d;
    logic       ffv_q,   ffv_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            mask_q  <= '0;
            nflt_q  <= '0;
            ffc_q   <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            mask_q  <= mask_d;
            nflt_q  <= nflt_d;
            ffc_q   <= ffc_d;
            ffv_q   <= ffv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        mask_d  = mask_q;
        nflt_d  = nflt_q;
        ffc_d   = ffc_q;
        ffv_d   = ffv_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_APPLY;
                    code_d  = '0;
                    mask_d  = '0;
                    nflt_d  = '0;
                    ffc_d   = '0;
                    ffv_d   = 1'b0;
                end
            end
            S_APPLY: begin
                state_d = S_SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                cap_d   = dut_q;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                mask_d = mask_q | chk_sa0out;
                if (chk_sa0out != 4'd0) begin
                    // saturate rather than wrap; a legal sweep tops out at 10
                    if (nflt_q != 4'hf) begin
                        nflt_d = nflt_q + 4'd1;
                    end
                    if (!ffv_q) begin
                        ffc_d = code_q;
                        ffv_d = 1'b1;
                    end
                end
                if (code_q < LAST_CODE) begin
                    code_d  = code_q + 4'd1;
                    state_d = S_APPLY;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign chk_din          = code_q;
    assign chk_q            = cap_q;
    assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done             = (state_q == S_DONE);
    assign fault_mask       = mask_q;
    assign fault_code_cnt   = nflt_q;
    assign first_fail_code  = ffc_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_sa0_test_sequencer.sv
// Scoreboard bench: expected sweep results and captures are queued at start,
// monitors pop and compare when done rises or chk_q updates.
module tb_sa0_test_sequencer;

    typedef struct {
        logic [3:0] m;
        int         c;
        int         f;
        int         v;
        int         cyc;
    } res_t;

    typedef struct {
        int val;
        int cyc;
    } cap_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start5;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    logic [3:0] dq0, din0, cq0, sa0, fm0, fc0, ff0;
    logic       busy0, done0, fv0;
    logic [3:0] dq5, din5, cq5, sa5, fm5, fc5, ff5;
    logic       busy5, done5, fv5;

    logic [3:0] tbl0 [10];

    res_t res_q0[$], res_q5[$];
    cap_t cap_q0[$], cap_q5[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dq0 = din0 + 4'd3;
    assign dq5 = din5 + 4'd3;
    assign sa0 = (din0 <= 4'd9) ? tbl0[din0] : 4'd0;
    assign sa5 = 4'd0;

    sa0_test_sequencer u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start0),
        .dut_q            (dq0),
        .chk_din          (din0),
        .chk_q            (cq0),
        .chk_sa0out       (sa0),
        .busy             (busy0),
        .done             (done0),
        .fault_mask       (fm0),
        .fault_code_cnt   (fc0),
        .first_fail_code  (ff0),
        .first_fail_valid (fv0)
    );

    sa0_test_sequencer #(.SETTLE_CYCLES(5)) u_dut5 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start5),
        .dut_q            (dq5),
        .chk_din          (din5),
        .chk_q            (cq5),
        .chk_sa0out       (sa5),
        .busy             (busy5),
        .done             (done5),
        .fault_mask       (fm5),
        .fault_code_cnt   (fc5),
        .first_fail_code  (ff5),
        .first_fail_valid (fv5)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_tbl(input logic [9:0] sel, input logic [3:0] v);
        for (int i = 0; i < 10; i++) tbl0[i] = sel[i] ? v : 4'd0;
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_din"},  din0,  0);
        chk({tag, "_q"},    cq0,   0);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_mask"}, fm0,   0);
        chk({tag, "_cnt"},  fc0,   0);
        chk({tag, "_ffc"},  ff0,   0);
        chk({tag, "_ffv"},  fv0,   0);
    endtask

    // Caller is on a negedge; start is sampled by the next posedge.
    task automatic sweep0(input logic [3:0] em, input int ec, input int ef,
                          input int ev, input bit poke);
        int st;
        int n;
        start0 = 1'b1;
        st = cyc + 1;
        res_q0.push_back('{em, ec, ef, ev, st + 50});
        for (int c = 0; c < 10; c++) cap_q0.push_back('{c + 3, st + c * 5 + 4});
        @(negedge clk);
        start0 = 1'b0;
        chk("apply_din", din0, 0);
        chk("apply_busy", busy0, 1);
        if (poke) begin
            while (cyc < st + 9) @(negedge clk);
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
        end
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done0_seen", done0, 1);
        repeat (4) @(negedge clk);
        chk("hold_done", done0, 1);
        chk("hold_mask", fm0, em);
        chk("hold_cnt", fc0, ec);
        chk("hold_din", din0, 9);
    endtask

    logic       dprev0 = 1'b0, dprev5 = 1'b0;
    logic [3:0] qprev0 = 4'd0, qprev5 = 4'd0;

    always @(negedge clk) begin
        res_t r;
        cap_t k;
        if (rst_n === 1'b1) begin
            if (done0 && !dprev0) begin
                if (res_q0.size() == 0) begin
                    chk("res0_unexpected", 1, 0);
                end else begin
                    r = res_q0.pop_front();
                    chk("res0_cycle", cyc, r.cyc);
                    chk("res0_mask", fm0, r.m);
                    chk("res0_cnt", fc0, r.c);
                    chk("res0_ffv", fv0, r.v);
                    chk("res0_ffc", ff0, r.f);
                end
            end
            if (cq0 !== qprev0) begin
                if (cap_q0.size() == 0) begin
                    chk("cap0_unexpected", cq0, qprev0);
                end else begin
                    k = cap_q0.pop_front();
                    chk("cap0_val", cq0, k.val);
                    chk("cap0_cycle", cyc, k.cyc);
                end
            end
        end
        dprev0 = done0;
        qprev0 = cq0;
    end

    always @(negedge clk) begin
        res_t r;
        cap_t k;
        if (rst_n === 1'b1) begin
            if (done5 && !dprev5) begin
                if (res_q5.size() == 0) begin
                    chk("res5_unexpected", 1, 0);
                end else begin
                    r = res_q5.pop_front();
                    chk("res5_cycle", cyc, r.cyc);
                    chk("res5_mask", fm5, r.m);
                    chk("res5_cnt", fc5, r.c);
                    chk("res5_ffv", fv5, r.v);
                end
            end
            if (cq5 !== qprev5) begin
                if (cap_q5.size() == 0) begin
                    chk("cap5_unexpected", cq5, qprev5);
                end else begin
                    k = cap_q5.pop_front();
                    chk("cap5_val", cq5, k.val);
                    chk("cap5_cycle", cyc, k.cyc);
                end
            end
        end
        dprev5 = done5;
        qprev5 = cq5;
    end

    initial begin
        int st;
        int n;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start5 = 1'b0;
        set_tbl(10'b0, 4'd0);
        repeat (3) @(negedge clk);
        chk_zero0("rst");
        chk("rst5_busy", busy5, 0);

        @(negedge clk);
        rst_n = 1'b1;
        sweep0(4'b0000, 0, 0, 0, 1'b0);

        set_tbl(10'b01_1001_1001, 4'b0010);
        @(negedge clk);
        sweep0(4'b0010, 5, 0, 1, 1'b0);

        set_tbl(10'b10_0000_0000, 4'b1000);
        @(negedge clk);
        sweep0(4'b1000, 1, 9, 1, 1'b0);

        set_tbl(10'b0, 4'd0);
        @(negedge clk);
        sweep0(4'b0000, 0, 0, 0, 1'b1);

        set_tbl(10'b01_1001_1001, 4'b0010);
        @(negedge clk);
        start0 = 1'b1;
        st = cyc + 1;
        for (int c = 0; c < 4; c++) cap_q0.push_back('{c + 3, st + c * 5 + 4});
        @(negedge clk);
        start0 = 1'b0;
        while (cyc < st + 23) @(negedge clk);
        chk("pre_rst_mask", fm0, 4'b0010);
        chk("pre_rst_din", din0, 4);
        #2 rst_n = 1'b0;
        #1 chk_zero0("midrst");
        chk("midrst_capq", cap_q0.size(), 0);
        cap_q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_tbl(10'b0, 4'd0);
        sweep0(4'b0000, 0, 0, 0, 1'b0);

        @(negedge clk);
        start5 = 1'b1;
        st = cyc + 1;
        res_q5.push_back('{4'd0, 0, 0, 0, st + 80});
        for (int c = 0; c < 10; c++) cap_q5.push_back('{c + 3, st + c * 8 + 7});
        @(negedge clk);
        start5 = 1'b0;
        n = 0;
        while (!done5 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done5_seen", done5, 1);
        repeat (3) @(negedge clk);

        chk("q0_empty", res_q0.size() + cap_q0.size(), 0);
        chk("q5_empty", res_q5.size() + cap_q5.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sa0_test_sequencer.md
SA0_TEST_SEQUENCER -- requirements
Module: sa0_test_sequencer

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 2, wait cycles between driving a code and capturing the converter output (legal range 1..15).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  sampled high in IDLE or DONE, begins a full BCD sweep.
REQ-006 dut_q  input  4  observed excess-3 output of the converter under test.
REQ-007 chk_din  output  4  BCD code currently applied to the converter and the SA0 checker.
REQ-008 chk_q  output  4  registered capture of dut_q, presented to the SA0 checker.
REQ-009 chk_sa0out  input  4  per-bit stuck-at-0 flags returned by the checker.
REQ-010 busy  output  1  high in every state except IDLE and DONE.
REQ-011 done  output  1  high while in DONE.
REQ-012 fault_mask  output  4  OR of all chk_sa0out values sampled during the sweep.
REQ-013 fault_code_cnt  output  4  number of codes whose sampled chk_sa0out was nonzero (0..10).
REQ-014 first_fail_code  output  4  first code, in sweep order, with nonzero chk_sa0out.
REQ-015 first_fail_valid  output  1  first_fail_code holds a valid value.

Function
REQ-016 The block SHALL implement states IDLE, APPLY, SETTLE, CAPTURE, CHECK and DONE.
REQ-017 IDLE/DONE with start=1 -> APPLY, code=0, with fault_mask, fault_code_cnt, first_fail_code and first_fail_valid cleared in the same edge.
REQ-018 APPLY: chk_din=code; next state SETTLE with settle counter loaded to SETTLE_CYCLES-1.
REQ-019 SETTLE: counter decrements each cycle; at 0 -> CAPTURE (exactly SETTLE_CYCLES cycles in SETTLE).
REQ-020 CAPTURE: chk_q <= dut_q on the exiting edge; next state CHECK.
REQ-021 CHECK: sample chk_sa0out; fault_mask |= chk_sa0out; if nonzero, fault_code_cnt += 1, and if first_fail_valid=0 then first_fail_code <= code and first_fail_valid <= 1.
REQ-022 CHECK with code<9 -> APPLY with code+1; with code=9 -> DONE; code never exceeds 9.
REQ-023 chk_din SHALL hold the current code from APPLY through CHECK and hold 9 in DONE.
REQ-024 Per-code latency SHALL be SETTLE_CYCLES+3 cycles; done SHALL rise exactly 10*(SETTLE_CYCLES+3) cycles after the edge that samples start (50 cycles at default).
REQ-025 start while busy=1 SHALL be ignored, with no effect on code or accumulators.
REQ-026 Result outputs SHALL hold stable in DONE until the next accepted start or reset.
REQ-027 fault_code_cnt SHALL NOT wrap (maximum 10 fits 4 bits).

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, code=0, chk_din=0, chk_q=0, settle counter=0, busy=0, done=0, fault_mask=0, fault_code_cnt=0, first_fail_code=0, first_fail_valid=0.
REQ-029 Reset asserted mid-sweep SHALL discard partial results; a start after release SHALL begin a fresh sweep at code 0.
REQ-030 The first start SHALL be accepted on the first rising edge after rst_n deassertion.

Verification
REQ-031 Fault-free: dut_q=din+3 model, checker returns 0 -> at done: fault_mask=0000, fault_code_cnt=0, first_fail_valid=0, done 50 cycles after start.
REQ-032 Bit-1 stuck-at-0: checker returns 0010 for codes 0,3,4,7,8 -> fault_mask=0010, fault_code_cnt=5, first_fail_code=0, first_fail_valid=1.
REQ-033 Single fault: checker returns 1000 only for code 9 -> fault_mask=1000, fault_code_cnt=1, first_fail_code=9.
REQ-034 start pulsed at cycle 10 of a sweep -> no restart; done still at cycle 50.
REQ-035 rst_n low at cycle 23 -> all outputs 0 asynchronously; start after release -> chk_din sequence restarts at 0.
REQ-036 SETTLE_CYCLES=5, fault-free -> done 80 cycles after start; chk_q equals dut_q sampled at each CAPTURE edge.
